hazard_ctrl_mc: RTL and testbench

Multi-cycle hazard controller for the 5-stage RISC-V core, sitting beside the ID stage and driving the PC, IF/ID and ID/EX control mux. Generalises single-cycle load-use detection to a parametrised load latency (N stall cycles), adds x0 filtering and per-operand use qualification, taken-branch flushing, and a whole-pipe freeze on data-memory wait. A small FSM with a stall counter makes the stall length independent of the decoder.

---
 rtl/hazard_ctrl_mc.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_mc
//  Description : Multi-cycle hazard controller for a 5-stage RISC-V pipeline.
//                Detects load-use hazards against the instruction in ID and
//                stalls for LOAD_LAT cycles. Flushes IF/ID on a taken branch
//                and freezes the whole pipe while data memory is busy.
//                Optional feature macro: HAZARD_PERF_EN
//                (adds the perf_stall_cycles and perf_flushes counters).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc #(
    parameter int REG_AW   = 5,
    // Load-use stall cycles, legal range 1..15.
    parameter int LOAD_LAT = 1,
    // Stall counter width, must satisfy 2**CNT_W > LOAD_LAT.
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              control_sel,
    output logic              pipe_hold,
    output logic              stall_active
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flushes
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Counter value loaded on entering STALL: the hit cycle itself is the
    // first bubble, so LOAD_LAT-1 bubbles remain.
    localparam logic [CNT_W-1:0] c_STALL_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_hit;
    logic             w_bubble;

    // Load-use hazard: a load in EX writes a non-x0 register that ID really reads.
    assign w_hit = ex_mem_read
                 & (ex_rd != '0)
                 & ((id_use_rs1 & (ex_rd == id_rs1))
                 |  (id_use_rs2 & (ex_rd == id_rs2)));

    // State and stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state and pipeline control in priority order: reset, busy, branch, hazard.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        control_sel  = 1'b0;
        pipe_hold    = 1'b0;
        w_bubble     = 1'b0;

        if (rst) begin
            // Reset holds the front end and keeps a bubble in ID/EX.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            control_sel  = 1'b1;
            w_next_state = ST_RUN;
            w_next_cnt   = '0;
        end else if (mem_busy) begin
            // Whole pipe frozen; state and counter hold their values.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (ex_branch_taken) begin
            // Taken branch squashes the wrong-path instructions and aborts any stall.
            if_id_flush  = 1'b1;
            control_sel  = 1'b1;
            w_next_state = ST_RUN;
            w_next_cnt   = '0;
        end else if (r_state == ST_STALL) begin
            // Remaining bubbles of a multi-cycle load-use stall; hit ignored here.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b1;
            w_bubble    = 1'b1;
            w_next_cnt  = r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
                w_next_state = ST_RUN;
            end
        end else if (w_hit) begin
            // First bubble is issued in the same cycle the hazard is seen.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b1;
            w_bubble    = 1'b1;
            if (LOAD_LAT > 1) begin
                w_next_state = ST_STALL;
                w_next_cnt   = c_STALL_INIT;
            end
        end
    end

    assign stall_active = (r_state == ST_STALL);

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Event counters; busy cycles never assert bubble or flush, so they freeze here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_bubble) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (if_id_flush) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flushes      = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_mc
//  Description : Directed self-checking bench for hazard_ctrl_mc. Three
//                instances (LOAD_LAT = 1, 2, 3) share one stimulus stream.
//                Output vector per instance:
//                {pc_write, if_id_write, if_id_flush, control_sel,
//                 pipe_hold, stall_active}
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_mc;

    localparam logic [5:0] c_NORM   = 6'b110000;
    localparam logic [5:0] c_BUB    = 6'b000100;
    localparam logic [5:0] c_BUB_ST = 6'b000101;
    localparam logic [5:0] c_BUSY   = 6'b000010;
    localparam logic [5:0] c_BSY_ST = 6'b000011;
    localparam logic [5:0] c_FLUSH  = 6'b111100;
    localparam logic [5:0] c_FLS_ST = 6'b111101;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;

    logic pcw1, ifw1, ifl1, cs1, ph1, sa1;
    logic pcw2, ifw2, ifl2, cs2, ph2, sa2;
    logic pcw3, ifw3, ifl3, cs3, ph3, sa3;
`ifdef HAZARD_PERF_EN
    logic [31:0] ps1, pf1, ps2, pf2, ps3, pf3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wire [5:0] v1 = {pcw1, ifw1, ifl1, cs1, ph1, sa1};
    wire [5:0] v2 = {pcw2, ifw2, ifl2, cs2, ph2, sa2};
    wire [5:0] v3 = {pcw3, ifw3, ifl3, cs3, ph3, sa3};

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) u_l1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write(pcw1), .if_id_write(ifw1),
        .if_id_flush(ifl1), .control_sel(cs1), .pipe_hold(ph1),
        .stall_active(sa1)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(ps1), .perf_flushes(pf1)
`endif
    );

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(4)) u_l2 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write(pcw2), .if_id_write(ifw2),
        .if_id_flush(ifl2), .control_sel(cs2), .pipe_hold(ph2),
        .stall_active(sa2)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(ps2), .perf_flushes(pf2)
`endif
    );

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_l3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write(pcw3), .if_id_write(ifw3),
        .if_id_flush(ifl3), .control_sel(cs3), .pipe_hold(ph3),
        .stall_active(sa3)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(ps3), .perf_flushes(pf3)
`endif
    );

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_mem_read     = 1'b0;
        ex_rd           = 5'd0;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
    endtask

    // Load in EX writing r9, read through rs1 by the instruction in ID.
    task automatic hazard_rs1();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd9;
        id_rs1      = 5'd9;
        id_use_rs1  = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        hazard_rs1();
        cyc();
        cyc();
        checks++; if (v1 !== c_BUB) begin errors++; $display("FAIL reset_l1 got %b exp %b", v1, c_BUB); end
        checks++; if (v2 !== c_BUB) begin errors++; $display("FAIL reset_l2 got %b exp %b", v2, c_BUB); end
        checks++; if (v3 !== c_BUB) begin errors++; $display("FAIL reset_l3 got %b exp %b", v3, c_BUB); end
        rst = 1'b0;
        idle();
        #1;
        checks++; if (v3 !== c_NORM) begin errors++; $display("FAIL reset_release_l3 got %b exp %b", v3, c_NORM); end
        cyc();
    endtask

    // rs2 hazard with an unrelated rs1 also read; the hazard lasts one cycle.
    task automatic test_load_use();
        logic [5:0] e1 [4] = '{c_BUB, c_NORM,   c_NORM,   c_NORM};
        logic [5:0] e2 [4] = '{c_BUB, c_BUB_ST, c_NORM,   c_NORM};
        logic [5:0] e3 [4] = '{c_BUB, c_BUB_ST, c_BUB_ST, c_NORM};
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i == 0) begin
                ex_mem_read = 1'b1; ex_rd = 5'd5;
                id_rs2 = 5'd5; id_use_rs2 = 1'b1;
                id_rs1 = 5'd6; id_use_rs1 = 1'b1;
            end
            #1;
            checks++; if (v1 !== e1[i]) begin errors++; $display("FAIL load_use_l1 c%0d got %b exp %b", i, v1, e1[i]); end
            checks++; if (v2 !== e2[i]) begin errors++; $display("FAIL load_use_l2 c%0d got %b exp %b", i, v2, e2[i]); end
            checks++; if (v3 !== e3[i]) begin errors++; $display("FAIL load_use_l3 c%0d got %b exp %b", i, v3, e3[i]); end
            cyc();
        end
    endtask

    // x0 destination, unused operand, and non-load producer never stall.
    task automatic test_no_hazard();
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; end
                1: begin ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
                         id_rs2 = 5'd3; id_use_rs2 = 1'b1; end
                2: begin ex_mem_read = 1'b0; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; end
                default: begin ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs2 = 5'd12; id_use_rs2 = 1'b0;
                         id_rs1 = 5'd13; id_use_rs1 = 1'b1; end
            endcase
            #1;
            checks++; if (v1 !== c_NORM) begin errors++; $display("FAIL no_hazard_l1 c%0d got %b exp %b", i, v1, c_NORM); end
            checks++; if (v3 !== c_NORM) begin errors++; $display("FAIL no_hazard_l3 c%0d got %b exp %b", i, v3, c_NORM); end
            cyc();
        end
    endtask

    // Two busy cycles in the middle of the stall: bubbles resume afterwards.
    task automatic test_busy_in_stall();
        logic [5:0] e1 [6] = '{c_BUB, c_BUSY,   c_BUSY,   c_NORM,   c_NORM,   c_NORM};
        logic [5:0] e2 [6] = '{c_BUB, c_BSY_ST, c_BSY_ST, c_BUB_ST, c_NORM,   c_NORM};
        logic [5:0] e3 [6] = '{c_BUB, c_BSY_ST, c_BSY_ST, c_BUB_ST, c_BUB_ST, c_NORM};
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) hazard_rs1();
            if (i == 1 || i == 2) mem_busy = 1'b1;
            #1;
            checks++; if (v1 !== e1[i]) begin errors++; $display("FAIL busy_stall_l1 c%0d got %b exp %b", i, v1, e1[i]); end
            checks++; if (v2 !== e2[i]) begin errors++; $display("FAIL busy_stall_l2 c%0d got %b exp %b", i, v2, e2[i]); end
            checks++; if (v3 !== e3[i]) begin errors++; $display("FAIL busy_stall_l3 c%0d got %b exp %b", i, v3, e3[i]); end
            cyc();
        end
    endtask

    // Busy in the cycle the hazard first appears defers the stall start.
    task automatic test_busy_on_hit();
        logic [5:0] e1 [5] = '{c_BUSY, c_BUB, c_NORM,   c_NORM,   c_NORM};
        logic [5:0] e3 [5] = '{c_BUSY, c_BUB, c_BUB_ST, c_BUB_ST, c_NORM};
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i <= 1) hazard_rs1();
            if (i == 0) mem_busy = 1'b1;
            #1;
            checks++; if (v1 !== e1[i]) begin errors++; $display("FAIL busy_hit_l1 c%0d got %b exp %b", i, v1, e1[i]); end
            checks++; if (v3 !== e3[i]) begin errors++; $display("FAIL busy_hit_l3 c%0d got %b exp %b", i, v3, e3[i]); end
            cyc();
        end
    endtask

    // Branch with hit, branch held by busy, and branch aborting a stall.
    task automatic test_branch();
        logic [5:0] e1 [8] = '{c_FLUSH, c_NORM, c_BUSY, c_FLUSH, c_NORM, c_BUB, c_FLUSH,  c_NORM};
        logic [5:0] e2 [8] = '{c_FLUSH, c_NORM, c_BUSY, c_FLUSH, c_NORM, c_BUB, c_FLS_ST, c_NORM};
        logic [5:0] e3 [8] = '{c_FLUSH, c_NORM, c_BUSY, c_FLUSH, c_NORM, c_BUB, c_FLS_ST, c_NORM};
        for (int i = 0; i < 8; i++) begin
            idle();
            case (i)
                0: begin hazard_rs1(); ex_branch_taken = 1'b1; end
                2: begin ex_branch_taken = 1'b1; mem_busy = 1'b1; end
                3: ex_branch_taken = 1'b1;
                5: hazard_rs1();
                6: ex_branch_taken = 1'b1;
                default: ;
            endcase
            #1;
            checks++; if (v1 !== e1[i]) begin errors++; $display("FAIL branch_l1 c%0d got %b exp %b", i, v1, e1[i]); end
            checks++; if (v2 !== e2[i]) begin errors++; $display("FAIL branch_l2 c%0d got %b exp %b", i, v2, e2[i]); end
            checks++; if (v3 !== e3[i]) begin errors++; $display("FAIL branch_l3 c%0d got %b exp %b", i, v3, e3[i]); end
            cyc();
        end
    endtask

    // Asynchronous reset in the middle of a stall returns to RUN at once.
    task automatic test_reset_mid_stall();
        idle();
        hazard_rs1();
        cyc();
        idle();
        #1;
        checks++; if (v3 !== c_BUB_ST) begin errors++; $display("FAIL rst_stall_pre got %b exp %b", v3, c_BUB_ST); end
        rst = 1'b1;
        #1;
        checks++; if (v3 !== c_BUB) begin errors++; $display("FAIL rst_stall_in got %b exp %b", v3, c_BUB); end
        checks++; if (v2 !== c_BUB) begin errors++; $display("FAIL rst_stall_in_l2 got %b exp %b", v2, c_BUB); end
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (v3 !== c_NORM) begin errors++; $display("FAIL rst_stall_post got %b exp %b", v3, c_NORM); end
        checks++; if (v2 !== c_NORM) begin errors++; $display("FAIL rst_stall_post_l2 got %b exp %b", v2, c_NORM); end
        cyc();
    endtask

`ifdef HAZARD_PERF_EN
    // Two load-use events, one busy cycle, one taken branch.
    task automatic test_perf();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (ps2 !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d exp 0", ps2); end
        for (int i = 0; i < 8; i++) begin
            idle();
            case (i)
                0, 3: hazard_rs1();
                6: mem_busy = 1'b1;
                7: ex_branch_taken = 1'b1;
                default: ;
            endcase
            cyc();
        end
        idle();
        #1;
        checks++; if (ps2 !== 32'd4) begin errors++; $display("FAIL perf_stall_l2 got %0d exp 4", ps2); end
        checks++; if (pf2 !== 32'd1) begin errors++; $display("FAIL perf_flush_l2 got %0d exp 1", pf2); end
        checks++; if (ps1 !== 32'd2) begin errors++; $display("FAIL perf_stall_l1 got %0d exp 2", ps1); end
        checks++; if (ps3 !== 32'd6) begin errors++; $display("FAIL perf_stall_l3 got %0d exp 6", ps3); end
        checks++; if (pf3 !== 32'd1) begin errors++; $display("FAIL perf_flush_l3 got %0d exp 1", pf3); end
        cyc();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_busy_in_stall();
        test_busy_on_hit();
        test_branch();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
